// File: rtl/calc_pkg.sv
// Shared definitions for the keyboard calculator sequencer:
// key codes, ALU op encoding, FSM states and digit-entry helpers.
package calc_pkg;

    localparam logic [3:0] KEY_EQ   = 4'd10;
    localparam logic [3:0] KEY_NONE = 4'd11;
    localparam logic [3:0] KEY_ADD  = 4'd12;
    localparam logic [3:0] KEY_SUB  = 4'd13;
    localparam logic [3:0] KEY_MUL  = 4'd14;
    localparam logic [3:0] KEY_DIV  = 4'd15;

    localparam logic [3:0] BLANK = 4'd11;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        OP_WAIT  = 3'd1,
        ENTER_B  = 3'd2,
        EXEC     = 3'd3,
        SHOW_RES = 3'd4,
        ERROR    = 3'd5
    } state_e;

    // Third and later digits leave the operand untouched.
    function automatic logic [6:0] digit_into(
        input logic [6:0] x,
        input logic [1:0] cnt,
        input logic [3:0] d
    );
        logic [6:0] r;
        if (cnt == 2'd0) begin
            r = {3'b000, d};
        end else if (cnt == 2'd1) begin
            r = 7'(x * 7'd10 + {3'b000, d});
        end else begin
            r = x;
        end
        return r;
    endfunction

    function automatic logic [1:0] count_next(input logic [1:0] cnt);
        return (cnt == 2'd2) ? 2'd2 : cnt + 2'd1;
    endfunction

endpackage

// File: rtl/calc_bcd_split.sv
// Splits a 0..99 value into tens/ones display digits,
// blanking the tens digit for single-digit values.
module calc_bcd_split
    import calc_pkg::*;
(
    input  logic [6:0] val_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    always_comb begin
        tens_o = 4'(val_i / 7'd10);
        ones_o = 4'(val_i % 7'd10);
        if (val_i < 7'd10) begin
            tens_o = BLANK;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: assembles two-digit operands from key events,
// runs the external ALU over start/done and drives the display.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [6:0]  alu_a,
    output logic [6:0]  alu_b,
    input  logic        alu_done,
    input  logic [13:0] alu_result,
    input  logic        alu_err,
    output logic [3:0]  disp_tens,
    output logic [3:0]  disp_ones,
    output logic        err,
    output logic        busy
);

    state_e     state_q, state_d;
    logic [6:0] a_q, a_d;
    logic [6:0] b_q, b_d;
    logic [1:0] cnt_q, cnt_d;
    alu_op_e    pend_q, pend_d;
    alu_op_e    next_q, next_d;
    logic       chain_q, chain_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;

    logic       start_q, start_d;
    alu_op_e    op_q, op_d;
    logic [6:0] opa_q, opa_d;
    logic [6:0] opb_q, opb_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;

    logic       acc;
    logic       is_digit;
    logic       is_eq;
    logic       is_op;
    alu_op_e    key_op;
    logic [6:0] disp_val;
    logic [3:0] split_tens;
    logic [3:0] split_ones;

    always_comb begin
        acc      = key_valid && (key_code != KEY_NONE);
        is_digit = acc && (key_code < KEY_EQ);
        is_eq    = acc && (key_code == KEY_EQ);
        is_op    = acc && ((key_code == KEY_ADD) || (key_code == KEY_SUB) ||
                           (key_code == KEY_MUL) || (key_code == KEY_DIV));
        key_op   = alu_op_e'(key_code[1:0]);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        next_d  = next_q;
        chain_d = chain_q;
        tmo_d   = tmo_q;
        start_d = 1'b0;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;

        unique case (state_q)
            ENTER_A: begin
                if (is_digit) begin
                    a_d   = digit_into(a_q, cnt_q, key_code);
                    cnt_d = count_next(cnt_q);
                end else if (is_op) begin
                    pend_d  = key_op;
                    state_d = OP_WAIT;
                end
            end
            OP_WAIT: begin
                if (is_digit) begin
                    b_d     = {3'b000, key_code};
                    cnt_d   = 2'd1;
                    state_d = ENTER_B;
                end else if (is_op) begin
                    pend_d = key_op;
                end
            end
            ENTER_B: begin
                if (is_digit) begin
                    b_d   = digit_into(b_q, cnt_q, key_code);
                    cnt_d = count_next(cnt_q);
                end else if (is_eq || is_op) begin
                    start_d = 1'b1;
                    op_d    = pend_q;
                    opa_d   = a_q;
                    opb_d   = b_q;
                    chain_d = is_op;
                    next_d  = key_op;
                    tmo_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // A done arriving on the timeout cycle still counts.
                if (alu_done) begin
                    if (alu_err || (alu_result > 14'd99)) begin
                        state_d = ERROR;
                    end else begin
                        a_d = 7'(alu_result);
                        if (chain_q) begin
                            pend_d  = next_q;
                            state_d = OP_WAIT;
                        end else begin
                            state_d = SHOW_RES;
                        end
                    end
                end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            SHOW_RES: begin
                if (is_digit) begin
                    a_d     = {3'b000, key_code};
                    cnt_d   = 2'd1;
                    state_d = ENTER_A;
                end else if (is_op) begin
                    pend_d  = key_op;
                    state_d = OP_WAIT;
                end
            end
            ERROR: begin
                if (is_digit) begin
                    a_d     = {3'b000, key_code};
                    cnt_d   = 2'd1;
                    state_d = ENTER_A;
                end
            end
            default: begin
                state_d = ENTER_A;
            end
        endcase
    end

    assign disp_val = (state_d == ENTER_B) ? b_d : a_d;

    calc_bcd_split u_split (
        .val_i  (disp_val),
        .tens_o (split_tens),
        .ones_o (split_ones)
    );

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        err_d  = (state_d == ERROR);
        busy_d = (state_d == EXEC);
        if (state_d == ERROR) begin
            tens_d = BLANK;
            ones_d = BLANK;
        end else if (state_d != EXEC) begin
            tens_d = split_tens;
            ones_d = split_ones;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            pend_q  <= OP_ADD;
            next_q  <= OP_ADD;
            chain_q <= 1'b0;
            tmo_q   <= '0;
            start_q <= 1'b0;
            op_q    <= OP_ADD;
            opa_q   <= '0;
            opb_q   <= '0;
            tens_q  <= BLANK;
            ones_q  <= 4'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            next_q  <= next_d;
            chain_q <= chain_d;
            tmo_q   <= tmo_d;
            start_q <= start_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign alu_start = start_q;
    assign alu_op    = op_q;
    assign alu_a     = opa_q;
    assign alu_b     = opb_q;
    assign disp_tens = tens_q;
    assign disp_ones = ones_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized and directed bench for calc_sequencer against a
// behavioural calculator model and a simple reactive ALU.
module tb_calc_sequencer;

    localparam int TIMEOUT = 64;

    localparam int M_A    = 0;
    localparam int M_OPW  = 1;
    localparam int M_B    = 2;
    localparam int M_EXEC = 3;
    localparam int M_RES  = 4;
    localparam int M_ERR  = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [6:0]  alu_a;
    logic [6:0]  alu_b;
    logic        alu_done;
    logic [13:0] alu_result;
    logic        alu_err;
    logic [3:0]  disp_tens;
    logic [3:0]  disp_ones;
    logic        err;
    logic        busy;

    int total = 0;
    int bad = 0;

    calc_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_err    (alu_err),
        .disp_tens  (disp_tens),
        .disp_ones  (disp_ones),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural calculator model
    int m_mode, m_a, m_b, m_cnt, m_pend, m_next, m_chain, m_age;
    int e_start, e_busy, e_op, e_a, e_b, e_tens, e_ones, e_err;

    function automatic int enter(input int x, input int cnt, input int d);
        if (cnt == 0) return d;
        if (cnt == 1) return x * 10 + d;
        return x;
    endfunction

    task model_reset();
        m_mode = M_A; m_a = 0; m_b = 0; m_cnt = 0;
        m_pend = 0; m_next = 0; m_chain = 0; m_age = 0;
        e_start = 0; e_busy = 0; e_op = 0; e_a = 0; e_b = 0;
        e_tens = 11; e_ones = 0; e_err = 0;
    endtask

    task model_step();
        int k, v;
        bit dig, op, eq;
        k = int'(key_code);
        dig = key_valid && k < 10;
        op = key_valid && k >= 12;
        eq = key_valid && k == 10;
        e_start = 0;
        case (m_mode)
            M_EXEC: begin
                if (alu_done) begin
                    if (alu_err || int'(alu_result) > 99) begin
                        m_mode = M_ERR;
                    end else begin
                        m_a = int'(alu_result);
                        if (m_chain != 0) begin
                            m_pend = m_next;
                            m_mode = M_OPW;
                        end else begin
                            m_mode = M_RES;
                        end
                    end
                end else begin
                    m_age++;
                    if (m_age >= TIMEOUT) m_mode = M_ERR;
                end
            end
            M_A: begin
                if (dig) begin
                    m_a = enter(m_a, m_cnt, k);
                    m_cnt = (m_cnt < 2) ? m_cnt + 1 : 2;
                end else if (op) begin
                    m_pend = k - 12;
                    m_mode = M_OPW;
                end
            end
            M_OPW: begin
                if (dig) begin
                    m_b = k; m_cnt = 1; m_mode = M_B;
                end else if (op) begin
                    m_pend = k - 12;
                end
            end
            M_B: begin
                if (dig) begin
                    m_b = enter(m_b, m_cnt, k);
                    m_cnt = (m_cnt < 2) ? m_cnt + 1 : 2;
                end else if (eq || op) begin
                    e_start = 1;
                    e_a = m_a; e_b = m_b; e_op = m_pend;
                    m_chain = op ? 1 : 0;
                    if (op) m_next = k - 12;
                    m_age = 0;
                    m_mode = M_EXEC;
                end
            end
            M_RES: begin
                if (dig) begin
                    m_a = k; m_cnt = 1; m_mode = M_A;
                end else if (op) begin
                    m_pend = k - 12;
                    m_mode = M_OPW;
                end
            end
            default: begin
                if (dig) begin
                    m_a = k; m_cnt = 1; m_mode = M_A;
                end
            end
        endcase
        e_busy = (m_mode == M_EXEC) ? 1 : 0;
        e_err = (m_mode == M_ERR) ? 1 : 0;
        if (m_mode == M_ERR) begin
            e_tens = 11; e_ones = 11;
        end else if (m_mode != M_EXEC) begin
            v = (m_mode == M_B) ? m_b : m_a;
            e_tens = (v < 10) ? 11 : v / 10;
            e_ones = v % 10;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    // Reactive ALU: answers rsp_delay cycles after the start pulse
    int rsp_delay = 4;
    int rsp_force_err = 0;
    logic st_seen = 1'b0;
    int dly_l = 0;
    int r_pend = 0;
    int r_cnt = 0;
    int r_dly = 0;

    always @(posedge clk) begin
        st_seen <= (alu_start === 1'b1);
        if (alu_start === 1'b1) dly_l <= rsp_delay;
    end

    always @(negedge clk) begin
        int res;
        bit e;
        alu_done = 1'b0;
        alu_err = 1'b0;
        alu_result = '0;
        if (st_seen) begin
            r_pend = (dly_l > 0) ? 1 : 0;
            r_cnt = 0;
            r_dly = dly_l;
        end
        if (r_pend != 0) begin
            r_cnt++;
            if (r_cnt == r_dly) begin
                r_pend = 0;
                e = 0;
                res = 0;
                case (e_op)
                    0: res = e_a + e_b;
                    1: if (e_a < e_b) e = 1; else res = e_a - e_b;
                    2: res = e_a * e_b;
                    default: if (e_b == 0) e = 1; else res = e_a / e_b;
                endcase
                if (rsp_force_err != 0) e = 1;
                alu_done = 1'b1;
                alu_err = e;
                alu_result = 14'(res);
            end
        end
    end

    // Checking and stimulus
    int cyc = 0;
    int n_busy = 0;
    int n_start = 0;
    int last_start = 0;
    int first_err = -1;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("alu_start", 32'(alu_start), e_start);
        chk("busy", 32'(busy), e_busy);
        chk("alu_op", 32'(alu_op), e_op);
        chk("alu_a", 32'(alu_a), e_a);
        chk("alu_b", 32'(alu_b), e_b);
        chk("disp_tens", 32'(disp_tens), e_tens);
        chk("disp_ones", 32'(disp_ones), e_ones);
        chk("err", 32'(err), e_err);
    endtask

    task automatic step(input bit kv, input int kc);
        key_valid = kv;
        key_code = 4'(kc);
        @(negedge clk);
        cyc++;
        if (busy === 1'b1) n_busy++;
        if (alu_start === 1'b1) begin
            n_start++;
            last_start = cyc;
        end
        if (err === 1'b1 && first_err < 0) first_err = cyc;
        check_all();
    endtask

    task automatic press(input int kc);
        step(1'b1, kc);
        step(1'b0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200; i++) begin
            if (e_busy == 0) break;
            step(1'b0, 0);
        end
        if (i >= 200) chk("wait_budget", 32'(i), 0);
        step(1'b0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 0);
        step(1'b0, 0);
        reset = 1'b1;
        step(1'b0, 0);
        n_busy = 0;
        n_start = 0;
        first_err = -1;
        rsp_force_err = 0;
    endtask

    initial begin
        int kc, r;
        reset = 1'b0;
        key_valid = 1'b0;
        key_code = 4'd0;
        @(negedge clk);
        do_reset();
        chk("rst_tens", 32'(disp_tens), 11);
        chk("rst_ones", 32'(disp_ones), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(alu_start), 0);

        // 12 + 34 = 46
        rsp_delay = 4;
        press(1); press(2); press(12); press(3); press(4); press(10);
        wait_idle();
        chk("t1_start_cnt", 32'(n_start), 1);
        chk("t1_busy_cycles", 32'(n_busy), 5);
        chk("t1_a", 32'(alu_a), 12);
        chk("t1_b", 32'(alu_b), 34);
        chk("t1_op", 32'(alu_op), 0);
        chk("t1_tens", 32'(disp_tens), 4);
        chk("t1_ones", 32'(disp_ones), 6);
        chk("t1_err", 32'(err), 0);

        // 9 * 9 chained into - 1
        do_reset();
        rsp_delay = 3;
        press(9); press(14); press(9); press(13);
        wait_idle();
        chk("t2_tens", 32'(disp_tens), 8);
        chk("t2_ones", 32'(disp_ones), 1);
        press(1); press(10);
        wait_idle();
        chk("t2_a", 32'(alu_a), 81);
        chk("t2_b", 32'(alu_b), 1);
        chk("t2_op", 32'(alu_op), 1);
        chk("t2_tens2", 32'(disp_tens), 8);
        chk("t2_ones2", 32'(disp_ones), 0);

        // 50 * 3 overflows the display
        do_reset();
        rsp_delay = 2;
        press(5); press(0); press(14); press(3); press(10);
        wait_idle();
        chk("t3_err", 32'(err), 1);
        chk("t3_tens", 32'(disp_tens), 11);
        chk("t3_ones", 32'(disp_ones), 11);
        press(7);
        chk("t3_clr_err", 32'(err), 0);
        chk("t3_clr_tens", 32'(disp_tens), 11);
        chk("t3_clr_ones", 32'(disp_ones), 7);

        // divide by zero
        do_reset();
        press(4); press(15); press(0); press(10);
        wait_idle();
        chk("t4_err", 32'(err), 1);

        // no reply: error exactly TIMEOUT cycles after start
        do_reset();
        rsp_delay = -1;
        press(2); press(12); press(3); press(10);
        for (int i = 0; i < 150 && first_err < 0; i++) step(1'b0, 0);
        chk("t4_timeout_lat", 32'(first_err - last_start), TIMEOUT);

        // reply on the last allowed cycle wins
        do_reset();
        rsp_delay = TIMEOUT - 1;
        press(2); press(12); press(3); press(10);
        wait_idle();
        chk("t4_edge_err", 32'(err), 0);
        chk("t4_edge_ones", 32'(disp_ones), 5);

        // reply one cycle too late is ignored
        do_reset();
        rsp_delay = TIMEOUT;
        press(2); press(12); press(3); press(10);
        wait_idle();
        idle(3);
        chk("t4_late_err", 32'(err), 1);

        // third digit ignored, last op wins, keys while busy dropped
        do_reset();
        rsp_delay = 10;
        press(1); press(2); press(3);
        chk("t5_tens", 32'(disp_tens), 1);
        chk("t5_ones", 32'(disp_ones), 2);
        press(12); press(13); press(14);
        press(5); press(10);
        press(9); press(12);
        chk("t5_busy", 32'(busy), 1);
        chk("t5_a", 32'(alu_a), 12);
        chk("t5_b", 32'(alu_b), 5);
        chk("t5_op", 32'(alu_op), 2);
        wait_idle();
        chk("t5_res_tens", 32'(disp_tens), 6);
        chk("t5_res_ones", 32'(disp_ones), 0);

        // asynchronous reset in the middle of EXEC
        do_reset();
        rsp_delay = 30;
        press(3); press(12); press(4); press(10);
        idle(3);
        #2 reset = 1'b0;
        #1;
        chk("t6_start", 32'(alu_start), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_tens", 32'(disp_tens), 11);
        chk("t6_ones", 32'(disp_ones), 0);
        chk("t6_a", 32'(alu_a), 0);
        chk("t6_b", 32'(alu_b), 0);
        step(1'b0, 0);
        reset = 1'b1;
        idle(40);
        chk("t6_late_busy", 32'(busy), 0);
        chk("t6_late_err", 32'(err), 0);
        chk("t6_late_tens", 32'(disp_tens), 11);
        chk("t6_late_ones", 32'(disp_ones), 0);

        // random key streams against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) rsp_delay = -1;
            else if (r == 1) rsp_delay = TIMEOUT - 1;
            else if (r == 2) rsp_delay = TIMEOUT + 3;
            else rsp_delay = int'($urandom_range(1, 12));
            rsp_force_err = ($urandom_range(0, 9) == 0) ? 1 : 0;
            r = int'($urandom_range(0, 19));
            if (r < 11) kc = int'($urandom_range(0, 9));
            else if (r < 14) kc = 12 + int'($urandom_range(0, 3));
            else if (r < 17) kc = 10;
            else kc = 11;
            step(r < 19, kc);
            idle(int'($urandom_range(0, 3)));
        end
        idle(TIMEOUT + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Control FSM for the keyboard calculator. It consumes decoded key events (digits and operators) from the scancode-decode stage and assembles two-digit unsigned operands. It issues operations to a multi-cycle arithmetic unit over a start/done handshake and drives the two-digit display value and error flag. It sits between the scancode decoder and the dec_2_7seg display drivers, and supports chaining of results as the next operand.

Parameters:
TIMEOUT, 64, max cycles to wait for alu_done after alu_start before declaring error
CNT_W, 7, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
key_valid  in  1  one-cycle pulse: key_code is a newly released key
key_code  in  4  0-9 digit, 10 equals, 11 invalid, 12 add, 13 sub, 14 mul, 15 div
alu_start  out  1  one-cycle request pulse to ALU
alu_op  out  2  00 add, 01 sub, 10 mul, 11 div; stable from start until done
alu_a  out  7  operand A (0..99), stable from start until done
alu_b  out  7  operand B (0..99), stable from start until done
alu_done  in  1  one-cycle pulse: alu_result/alu_err valid
alu_result  in  14  unsigned result (max 9801)
alu_err  in  1  ALU error (divide by zero, negative subtraction)
disp_tens  out  4  tens digit; 11 = blank
disp_ones  out  4  ones digit; 11 = blank
err  out  1  error indicator
busy  out  1  high while waiting for ALU

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low; asserting it forces the reset state from any state, including EXEC.
- Reset values: state ENTER_A, A=0, B=0, digit count 0, alu_start=0, alu_op=00, alu_a=0, alu_b=0, disp_tens=11, disp_ones=0, err=0, busy=0.
- All outputs are registered. A key accepted at cycle N is reflected on the outputs at N+1.
- Key code 11, and key_valid while busy, are dropped with no state change.
- Digit entry into the current operand X:
  - count 0: X=d, count becomes 1.
  - count 1: X=X*10+d, count becomes 2.
  - count 2: digit ignored.
  - Leading zero is permitted (0 then 5 gives 5).
- States and transitions:
  - ENTER_A
    - digit: enter into A.
    - op: store pending op, go to OP_WAIT.
    - equals: ignored.
  - OP_WAIT
    - digit: B=d, count=1, go to ENTER_B.
    - op: replaces pending op.
    - equals: ignored.
  - ENTER_B
    - digit: enter into B.
    - equals: launch, next_op=none.
    - op: launch, next_op=that op (chained).
  - EXEC
    - Entry cycle: alu_start=1 for exactly one cycle; busy=1; timeout counter cleared.
    - alu_done with alu_err=1, or alu_result>99: go to ERROR.
    - Otherwise A=alu_result. If next_op is set: pending=next_op, go to OP_WAIT. Else go to SHOW_RES.
    - Counter reaches TIMEOUT without alu_done: go to ERROR.
    - alu_done in the same cycle the counter hits TIMEOUT: done wins.
    - busy drops on exit.
  - SHOW_RES
    - digit: A=d, count=1, go to ENTER_A.
    - op: result is operand A; pending=op; go to OP_WAIT.
    - equals: ignored.
  - ERROR
    - digit: err=0, A=d, count=1, go to ENTER_A.
    - op and equals: ignored.
- alu_done outside EXEC is ignored.
- Display:
  - ENTER_A, OP_WAIT and SHOW_RES show A; ENTER_B shows B; EXEC holds the previous display.
  - Tens digit is blank (11) when the value is <10. ERROR shows 11/11 with err=1.

Decomposition:
- Shared package calc_pkg holds:
  - key-code constants (KEY_EQ=10, KEY_NONE=11, KEY_ADD..KEY_DIV=12..15);
  - ALU op encoding;
  - state enum (ENTER_A, OP_WAIT, ENTER_B, EXEC, SHOW_RES, ERROR);
  - BLANK=11.
- One sub-module: calc_bcd_split, a combinational 0..99 binary to tens/ones split with leading-blank handling. The ALU itself is external.

Test Plan:
- Keys 1,2,+,3,4,= with ALU replying done after 5 cycles with 46 -> alu_start pulses once with a=12, b=34, op=00; busy high 5 cycles; display 4/6; err=0.
- Keys 9,*,9,- (chain), ALU 81 -> OP_WAIT with display 8/1. Then 1,=, ALU 80 -> alu_a=81, alu_b=1, op=01; display 8/0.
- Keys 5,0,*,3,= with ALU returning 150 -> ERROR, display 11/11, err=1. Then digit 7 -> err=0, display 11/7.
- Keys 4,/,0,= with alu_err=1 -> ERROR. Separately, with alu_done never asserted -> ERROR exactly TIMEOUT cycles after alu_start.
- Keys 1,2,3 -> display 1/2 (third digit ignored). Op then op -> the last op is used. key_valid during busy -> no effect on alu_a/alu_b/state.
- reset driven low mid-EXEC -> immediate reset values. A late alu_done after reset release -> ignored.
